// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code constants, frame FSM states and a parity helper.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the raw PS/2 lines and the decoded key outputs; slave is the decoder side.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_data;
  logic       in_valid;
  logic       key_ext;
  logic       code_strobe;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  key_data, in_valid, key_ext, code_strobe, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_data, in_valid, key_ext, code_strobe, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver; byte_valid/frame_err are
// single-cycle strobes aligned with the stop-bit sample cycle.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          edge_seen, fall;

  assign rx_byte = shift_q;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    edge_seen  = 1'b0;
    // A new level is taken only after FILTER_LEN consecutive differing samples.
    if (clk_sync_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d     = clk_sync_q;
      filt_cnt_d = '0;
      edge_seen  = 1'b1;
    end else begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
    fall = edge_seen & filt_q;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    tmo_d      = (edge_seen || state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_sync_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_sync_q && odd_parity_ok(shift_q, par_q)) byte_valid = 1'b1;
          else                                               frame_err  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d   = ST_IDLE;
      frame_err = 1'b1;
      tmo_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: frame receiver plus E0/F0 scan layer holding the
// most recently pressed key until its matching break code arrives.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic               clk,
  input logic               rst,
  ps2_key_decoder_if.slave  bus
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  logic [7:0] key_data_q, key_data_d;
  logic       in_valid_q, in_valid_d;
  logic       key_ext_q, key_ext_d;
  logic       strobe_q, strobe_d;
  logic       err_q, err_d;
  logic       ext_flag_q, ext_flag_d;
  logic       brk_flag_q, brk_flag_d;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  always_comb begin
    key_data_d = key_data_q;
    in_valid_d = in_valid_q;
    key_ext_d  = key_ext_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    ext_flag_d = ext_flag_q;
    brk_flag_d = brk_flag_q;
    // An error in the same cycle as a byte suppresses the byte.
    if (rx_err) begin
      err_d      = 1'b1;
      ext_flag_d = 1'b0;
      brk_flag_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_flag_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_flag_d = 1'b1;
      end else begin
        strobe_d   = 1'b1;
        ext_flag_d = 1'b0;
        brk_flag_d = 1'b0;
        if (!brk_flag_q) begin
          key_data_d = rx_byte;
          key_ext_d  = ext_flag_q;
          in_valid_d = 1'b1;
        end else if (rx_byte == key_data_q && ext_flag_q == key_ext_q) begin
          in_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_data_q <= 8'h00;
      in_valid_q <= 1'b0;
      key_ext_q  <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      ext_flag_q <= 1'b0;
      brk_flag_q <= 1'b0;
    end else begin
      key_data_q <= key_data_d;
      in_valid_q <= in_valid_d;
      key_ext_q  <= key_ext_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      ext_flag_q <= ext_flag_d;
      brk_flag_q <= brk_flag_d;
    end
  end

  assign bus.key_data    = key_data_q;
  assign bus.in_valid    = in_valid_q;
  assign bus.key_ext     = key_ext_q;
  assign bus.code_strobe = strobe_q;
  assign bus.frame_err   = err_q;

endmodule
